rs232in_fifo: RTL and testbench

Receive-side byte buffer that sits directly downstream of the serial receiver. It captures each byte the receiver announces with a one-cycle `attention` pulse and stores it in a small first-word-fall-through FIFO. It presents the bytes to the consumer (CPU I/O register or monitor) over a valid/ready handshake. It reports occupancy and a sticky overflow flag so software can detect lost bytes.

---
 rtl/rs232in_fifo.sv | 86 ++++++++
 tb/tb_rs232in_fifo.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/rs232in_fifo.sv
// Receive-side byte FIFO behind the serial receiver: first-word-fall-through storage,
// valid/ready output, occupancy count and a sticky overflow flag for dropped bytes.
module rs232in_fifo #(
    parameter int unsigned ADDR_BITS = 4
) (
    input  logic                 clk25MHz,
    input  logic                 reset_n,
    input  logic                 in_attention,
    input  logic [7:0]           in_data,
    output logic                 out_valid,
    output logic [7:0]           out_data,
    input  logic                 out_ready,
    output logic [ADDR_BITS:0]   count,
    output logic                 full,
    output logic                 overflow,
    input  logic                 overflow_clear
);

    localparam int unsigned Depth = 2 ** ADDR_BITS;
    localparam logic [ADDR_BITS:0] FullCount = {1'b1, {ADDR_BITS{1'b0}}};

    logic [7:0]           mem_q [Depth];
    logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_BITS:0]   count_q, count_d;
    logic                 overflow_q, overflow_d;

    logic push, pop, drop;

    // Status flags come straight from the registered count.
    assign out_valid = (count_q != '0);
    assign full      = (count_q == FullCount);
    assign count     = count_q;
    assign overflow  = overflow_q;

    assign pop  = out_valid & out_ready;
    assign push = in_attention & (~full | pop);
    assign drop = in_attention & full & ~pop;

    // Head is zeroed while empty so the unreset array never shows through.
    assign out_data = out_valid ? mem_q[rd_ptr_q] : 8'h00;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // A drop in the same cycle as a clear keeps the flag set.
        if (drop) begin
            overflow_d = 1'b1;
        end else if (overflow_clear) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk25MHz or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk25MHz) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

endmodule

// File: tb/tb_rs232in_fifo.sv
// Self-checking bench for rs232in_fifo: queue-based reference model with a negedge monitor
// plus directed checks for single byte, fill, overflow, full push/pop, wrap and async reset.
module tb_rs232in_fifo;

    localparam int unsigned AB    = 4;
    localparam int unsigned DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          in_attention = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          out_valid;
    logic [7:0]    out_data;
    logic          out_ready = 1'b0;
    logic [AB:0]   count;
    logic          full;
    logic          overflow;
    logic          overflow_clear = 1'b0;

    int tests  = 0;
    int failed = 0;

    // Reference model state
    logic [7:0] exp_q[$];
    bit         ovf_m = 1'b0;
    bit         pop_pending = 1'b0;
    int         pre_size = 0;

    rs232in_fifo #(.ADDR_BITS(AB)) dut (
        .clk25MHz       (clk),
        .reset_n        (reset_n),
        .in_attention   (in_attention),
        .in_data        (in_data),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .out_ready      (out_ready),
        .count          (count),
        .full           (full),
        .overflow       (overflow),
        .overflow_clear (overflow_clear)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge reset_n) begin
        exp_q.delete();
        ovf_m       = 1'b0;
        pop_pending = 1'b0;
        pre_size    = 0;
    end

    // Monitor: compare status every cycle, compare and pop the head when consumed.
    always @(negedge clk) begin
        pre_size = exp_q.size();
        chk("count", int'(count), pre_size);
        chk("out_valid", int'(out_valid), int'(pre_size != 0));
        chk("full", int'(full), int'(pre_size == DEPTH));
        chk("overflow", int'(overflow), int'(ovf_m));
        if (pre_size != 0) begin
            chk("out_data", int'(out_data), int'(exp_q[0]));
            if (out_ready) begin
                void'(exp_q.pop_front());
                pop_pending = 1'b1;
            end
        end
    end

    // Model: bytes are accepted if there was room or a pop freed a slot this cycle.
    always @(posedge clk) begin
        if (reset_n) begin
            if (in_attention) begin
                if (pre_size < DEPTH || pop_pending) begin
                    exp_q.push_back(in_data);
                end else begin
                    ovf_m = 1'b1;
                end
            end
            if (overflow_clear && !(in_attention && pre_size == DEPTH && !pop_pending)) begin
                ovf_m = 1'b0;
            end
            pop_pending = 1'b0;
        end
    end

    task automatic step(input logic a, input logic [7:0] d, input logic r, input logic clr);
        in_attention   = a;
        in_data        = d;
        out_ready      = r;
        overflow_clear = clr;
        @(posedge clk);
        #1;
        in_attention   = 1'b0;
        out_ready      = 1'b0;
        overflow_clear = 1'b0;
    endtask

    initial begin
        int sent;
        int budget;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_count", int'(count), 0);
        chk("reset_valid", int'(out_valid), 0);
        chk("reset_overflow", int'(overflow), 0);
        reset_n = 1'b1;

        // Single byte
        step(1'b1, 8'h41, 1'b0, 1'b0);
        chk("single_valid", int'(out_valid), 1);
        chk("single_data", int'(out_data), 'h41);
        chk("single_count", int'(count), 1);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("single_pop_valid", int'(out_valid), 0);
        chk("single_pop_count", int'(count), 0);

        // Fill
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        chk("fill_full", int'(full), 1);
        chk("fill_count", int'(count), DEPTH);
        chk("fill_overflow", int'(overflow), 0);

        // Overflow, clear racing a drop, then clear alone
        step(1'b1, 8'hAA, 1'b0, 1'b0);
        chk("ovf_set", int'(overflow), 1);
        chk("ovf_count", int'(count), DEPTH);
        step(1'b1, 8'hBB, 1'b0, 1'b1);
        chk("ovf_clear_vs_drop", int'(overflow), 1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("ovf_clear", int'(overflow), 0);

        // Full with simultaneous push and pop
        step(1'b1, 8'h55, 1'b1, 1'b0);
        chk("fullpp_count", int'(count), DEPTH);
        chk("fullpp_overflow", int'(overflow), 0);
        chk("fullpp_head", int'(out_data), 'h01);

        // Drain: model checks 01..0F then 55
        for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("drain_valid", int'(out_valid), 0);
        chk("drain_count", int'(count), 0);

        // Pointer wrap with random back-pressure, never overflowing
        sent = 0;
        budget = 0;
        while (sent < 40 && budget < 2000) begin
            logic a;
            a = ($urandom_range(0, 1) == 1) && (exp_q.size() < DEPTH);
            step(a, 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
            if (a) sent++;
            budget++;
        end
        chk("wrap_sent", sent, 40);
        budget = 0;
        while (exp_q.size() != 0 && budget < 100) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            budget++;
        end
        chk("wrap_drained", int'(count), 0);
        chk("wrap_overflow", int'(overflow), 0);

        // Build count=5 with overflow set, then reset between edges
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
        step(1'b1, 8'hEE, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH - 5; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("pre_reset_count", int'(count), 5);
        chk("pre_reset_overflow", int'(overflow), 1);
        #1 reset_n = 1'b0;
        #1;
        chk("async_valid", int'(out_valid), 0);
        chk("async_count", int'(count), 0);
        chk("async_overflow", int'(overflow), 0);
        @(negedge clk);
        #1 reset_n = 1'b1;
        step(1'b1, 8'h7E, 1'b0, 1'b0);
        chk("post_reset_valid", int'(out_valid), 1);
        chk("post_reset_data", int'(out_data), 'h7E);
        chk("post_reset_count", int'(count), 1);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("post_reset_sole", int'(out_valid), 0);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
